// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module  : regfile_pkg
// Brief   : Shared constants and helpers for the multi-port register file.
// Revision: 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;

    // When two write ports hit the same register, the higher port index wins.
    localparam bit c_WR_HIGHEST_WINS = 1'b1;

    function automatic int aw_of(input int n);
        return $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
// Module  : regfile_mp_if
// Brief   : Read/write/issue/debug bundle between the pipeline and regfile_mp.
// Revision: 1.0 - initial release
// ============================================================================
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = NREGS_DEFAULT,
    parameter int NRD   = 2,
    parameter int NWR   = 1
);
    localparam int AW = aw_of(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic [AW-1:0]       dbg_addr;
    logic [XLEN-1:0]     dbg_data;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_valid, iss_rd, dbg_addr,
        input  rd_data, rd_busy, dbg_data
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_valid, iss_rd, dbg_addr,
        output rd_data, rd_busy, dbg_data
    );

endinterface
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : rf_scoreboard
// Brief   : Per-register busy bits with issue/writeback update and read masking.
// Revision: 1.0 - initial release
// ============================================================================
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT,
    parameter int NWR   = 1,
    parameter int NRD   = 2,
    parameter int AW    = aw_of(NREGS)
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic [NRD*AW-1:0] i_rd_addr,
    input  wire logic [NWR-1:0]    i_wr_en,
    input  wire logic [NWR*AW-1:0] i_wr_addr,
    input  wire logic              i_iss_valid,
    input  wire logic [AW-1:0]     i_iss_rd,
    output logic      [NRD-1:0]    o_rd_busy
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;

    // Clears are applied first so a same-cycle issue to the same register wins.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int j = 0; j < NWR; j++) begin
            if (i_wr_en[j]) begin
                w_busy_nxt[i_wr_addr[j*AW +: AW]] = 1'b0;
            end
        end
        if (i_iss_valid) begin
            w_busy_nxt[i_iss_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd_busy
        logic [AW-1:0] w_ra;
        logic          w_hit;

        assign w_ra = i_rd_addr[k*AW +: AW];

        always_comb begin
            w_hit = 1'b0;
            for (int j = 0; j < NWR; j++) begin
                if (i_wr_en[j] && (i_wr_addr[j*AW +: AW] == w_ra)) begin
                    w_hit = 1'b1;
                end
            end
        end

        assign o_rd_busy[k] = r_busy[w_ra] & ~w_hit;
    end

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module  : regfile_mp
// Brief   : NRD-read / NWR-write register file with same-cycle bypass and busy scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = NREGS_DEFAULT,
    parameter int NRD   = 2,
    parameter int NWR   = 1
) (
    input wire logic     clk,
    input wire logic     rst_n,
    regfile_mp_if.slave  bus
);

    localparam int AW = aw_of(NREGS);

    logic [XLEN-1:0] r_mem [NREGS];
    logic [AW-1:0]   w_wa  [NWR];
    logic [XLEN-1:0] w_wd  [NWR];

    // Order in which write ports are applied; the last one applied wins.
    function automatic int wr_port(input int j);
        return c_WR_HIGHEST_WINS ? j : (NWR - 1 - j);
    endfunction

    for (genvar p = 0; p < NWR; p++) begin : g_wr
        assign w_wa[p] = bus.wr_addr[p*AW +: AW];
        assign w_wd[p] = bus.wr_data[p*XLEN +: XLEN];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (bus.wr_en[wr_port(j)] && (w_wa[wr_port(j)] != '0)) begin
                    r_mem[w_wa[wr_port(j)]] <= w_wd[wr_port(j)];
                end
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic [XLEN-1:0] w_data;

        assign w_ra = bus.rd_addr[k*AW +: AW];

        // The reset gate keeps in-flight write data off the bypass while rst_n is low.
        always_comb begin
            w_data = r_mem[w_ra];
            for (int j = 0; j < NWR; j++) begin
                if (bus.wr_en[wr_port(j)] && (w_wa[wr_port(j)] == w_ra)) begin
                    w_data = w_wd[wr_port(j)];
                end
            end
            if ((w_ra == '0) || !rst_n) begin
                w_data = '0;
            end
        end

        assign bus.rd_data[k*XLEN +: XLEN] = w_data;
    end

    assign bus.dbg_data = (bus.dbg_addr == '0) ? '0 : r_mem[bus.dbg_addr];

    rf_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR),
        .NRD   (NRD),
        .AW    (AW)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rd_addr   (bus.rd_addr),
        .i_wr_en     (bus.wr_en),
        .i_wr_addr   (bus.wr_addr),
        .i_iss_valid (bus.iss_valid),
        .i_iss_rd    (bus.iss_rd),
        .o_rd_busy   (bus.rd_busy)
    );

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_mp
// Brief   : Directed vector table, reset sequence and model-checked random phase for regfile_mp.
// Revision: 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [4:0]  da;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
        logic [31:0] ed;
    } vec_t;

    vec_t vq[$];

    logic [31:0] m_mem  [NREGS];
    logic        m_busy [NREGS];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                         input logic [4:0] wa1, input logic [31:0] wd1, input logic iv,
                         input logic [4:0] ird, input logic [4:0] ra0, input logic [4:0] ra1,
                         input logic [4:0] da);
        bus.wr_en     = we;
        bus.wr_addr   = {wa1, wa0};
        bus.wr_data   = {wd1, wd0};
        bus.iss_valid = iv;
        bus.iss_rd    = ird;
        bus.rd_addr   = {ra1, ra0};
        bus.dbg_addr  = da;
    endtask

    function automatic logic [31:0] m_rd(input logic [4:0] a, input logic [1:0] we,
                                         input logic [4:0] wa0, input logic [31:0] wd0,
                                         input logic [4:0] wa1, input logic [31:0] wd1);
        if (a == 5'd0) return 32'h0;
        if (we[1] && wa1 == a) return wd1;
        if (we[0] && wa0 == a) return wd0;
        return m_mem[a];
    endfunction

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 0, 0);

        //               we     wa0 wd0           wa1 wd1           iv  ird ra0 ra1 da  e0            e1            eb     ed
        vq.push_back(vec_t'{2'b00, 0, 32'h0,        0, 32'h0,        0, 0,  0,  5,  5,  32'h0,        32'h0,        2'b00, 32'h0});
        vq.push_back(vec_t'{2'b01, 5, 32'hDEADBEEF, 0, 32'h0,        0, 0,  5,  6,  5,  32'hDEADBEEF, 32'h0,        2'b00, 32'h0});
        vq.push_back(vec_t'{2'b01, 0, 32'h1234,     0, 32'h0,        0, 0,  0,  5,  0,  32'h0,        32'hDEADBEEF, 2'b00, 32'h0});
        vq.push_back(vec_t'{2'b01, 7, 32'hA5A5A5A5, 0, 32'h0,        0, 0,  7,  0,  7,  32'hA5A5A5A5, 32'h0,        2'b00, 32'h0});
        vq.push_back(vec_t'{2'b00, 0, 32'h0,        0, 32'h0,        0, 0,  7,  5,  7,  32'hA5A5A5A5, 32'hDEADBEEF, 2'b00, 32'hA5A5A5A5});
        vq.push_back(vec_t'{2'b11, 3, 32'h11,       3, 32'h22,       0, 0,  3,  3,  3,  32'h22,       32'h22,       2'b00, 32'h0});
        vq.push_back(vec_t'{2'b00, 0, 32'h0,        0, 32'h0,        0, 0,  3,  0,  3,  32'h22,       32'h0,        2'b00, 32'h22});
        vq.push_back(vec_t'{2'b00, 0, 32'h0,        0, 32'h0,        1, 9,  9,  5,  9,  32'h0,        32'hDEADBEEF, 2'b00, 32'h0});
        vq.push_back(vec_t'{2'b00, 0, 32'h0,        0, 32'h0,        0, 0,  9,  5,  9,  32'h0,        32'hDEADBEEF, 2'b01, 32'h0});
        vq.push_back(vec_t'{2'b10, 0, 32'h0,        9, 32'h55,       0, 0,  9,  9,  9,  32'h55,       32'h55,       2'b00, 32'h0});
        vq.push_back(vec_t'{2'b01, 9, 32'h66,       0, 32'h0,        1, 9,  9,  5,  9,  32'h66,       32'hDEADBEEF, 2'b00, 32'h55});
        vq.push_back(vec_t'{2'b00, 0, 32'h0,        0, 32'h0,        0, 0,  9,  9,  9,  32'h66,       32'h66,       2'b11, 32'h66});
        vq.push_back(vec_t'{2'b01, 9, 32'h77,       0, 32'h0,        0, 0,  9,  3,  9,  32'h77,       32'h22,       2'b00, 32'h66});
        vq.push_back(vec_t'{2'b00, 0, 32'h0,        0, 32'h0,        0, 0,  9,  9,  9,  32'h77,       32'h77,       2'b00, 32'h77});
        vq.push_back(vec_t'{2'b11, 13, 32'h1313,    12, 32'hCAFE,    0, 0,  12, 13, 12, 32'hCAFE,     32'h1313,     2'b00, 32'h0});
        vq.push_back(vec_t'{2'b00, 0, 32'h0,        0, 32'h0,        0, 0,  12, 13, 13, 32'hCAFE,     32'h1313,     2'b00, 32'h1313});
        vq.push_back(vec_t'{2'b00, 0, 32'h0,        0, 32'h0,        1, 0,  0,  12, 0,  32'h0,        32'hCAFE,     2'b00, 32'h0});
        vq.push_back(vec_t'{2'b00, 0, 32'h0,        0, 32'h0,        0, 0,  0,  12, 0,  32'h0,        32'hCAFE,     2'b00, 32'h0});

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i].we, vq[i].wa0, vq[i].wd0, vq[i].wa1, vq[i].wd1,
                  vq[i].iv, vq[i].ird, vq[i].ra0, vq[i].ra1, vq[i].da);
            #1;
            chk($sformatf("v%0d rd0", i), 64'(bus.rd_data[31:0]), 64'(vq[i].e0));
            chk($sformatf("v%0d rd1", i), 64'(bus.rd_data[63:32]), 64'(vq[i].e1));
            chk($sformatf("v%0d busy", i), 64'(bus.rd_busy), 64'(vq[i].eb));
            chk($sformatf("v%0d dbg", i), 64'(bus.dbg_data), 64'(vq[i].ed));
        end

        // Async reset in the middle of a pending write with busy registers outstanding.
        @(negedge clk);
        drive(2'b00, 0, 0, 0, 0, 1'b1, 4, 0, 0, 0);
        @(negedge clk);
        drive(2'b00, 0, 0, 0, 0, 1'b1, 8, 0, 0, 0);
        @(negedge clk);
        drive(2'b01, 4, 32'h77, 0, 0, 1'b0, 0, 4, 8, 5);
        #1;
        chk("pre_rst rd0", 64'(bus.rd_data[31:0]), 64'h77);
        chk("pre_rst busy", 64'(bus.rd_busy), 64'h2);
        chk("pre_rst dbg", 64'(bus.dbg_data), 64'hDEADBEEF);
        #1 rst_n = 1'b0;
        #1;
        chk("in_rst rd0", 64'(bus.rd_data[31:0]), 64'h0);
        chk("in_rst busy", 64'(bus.rd_busy), 64'h0);
        chk("in_rst dbg", 64'(bus.dbg_data), 64'h0);
        @(posedge clk);
        #1;
        chk("rst_edge rd0", 64'(bus.rd_data[31:0]), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 4, 8, 5);
        #1;
        chk("post_rst rd0", 64'(bus.rd_data[31:0]), 64'h0);
        chk("post_rst busy", 64'(bus.rd_busy), 64'h0);
        chk("post_rst dbg", 64'(bus.dbg_data), 64'h0);
        @(negedge clk);
        drive(2'b01, 4, 32'h99, 0, 0, 1'b0, 0, 4, 0, 4);
        @(negedge clk);
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 0, 4);
        #1;
        chk("first_edge dbg", 64'(bus.dbg_data), 64'h99);

        // Random traffic against a reference model, starting from a fresh reset.
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            m_mem[i]  = 32'h0;
            m_busy[i] = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 400; c++) begin
            logic [1:0]  we;
            logic [4:0]  wa0, wa1, ird, ra0, ra1, da;
            logic [31:0] wd0, wd1;
            logic        iv;
            logic        hit0, hit1;
            @(negedge clk);
            we  = 2'($urandom_range(0, 3));
            wa0 = 5'($urandom_range(0, 7));
            wa1 = 5'($urandom_range(0, 7));
            wd0 = $urandom;
            wd1 = $urandom;
            iv  = 1'($urandom_range(0, 1));
            ird = 5'($urandom_range(0, 7));
            ra0 = 5'($urandom_range(0, 7));
            ra1 = 5'($urandom_range(0, 7));
            da  = 5'($urandom_range(0, 7));
            drive(we, wa0, wd0, wa1, wd1, iv, ird, ra0, ra1, da);
            hit0 = (we[0] && wa0 == ra0) || (we[1] && wa1 == ra0);
            hit1 = (we[0] && wa0 == ra1) || (we[1] && wa1 == ra1);
            #1;
            chk($sformatf("rnd%0d rd0", c), 64'(bus.rd_data[31:0]), 64'(m_rd(ra0, we, wa0, wd0, wa1, wd1)));
            chk($sformatf("rnd%0d rd1", c), 64'(bus.rd_data[63:32]), 64'(m_rd(ra1, we, wa0, wd0, wa1, wd1)));
            chk($sformatf("rnd%0d busy", c), 64'(bus.rd_busy),
                64'({m_busy[ra1] && !hit1, m_busy[ra0] && !hit0}));
            chk($sformatf("rnd%0d dbg", c), 64'(bus.dbg_data), 64'(m_mem[da]));
            if (we[0] && wa0 != 5'd0) m_mem[wa0] = wd0;
            if (we[1] && wa1 != 5'd0) m_mem[wa1] = wd1;
            if (we[0]) m_busy[wa0] = 1'b0;
            if (we[1]) m_busy[wa1] = 1'b0;
            if (iv && ird != 5'd0) m_busy[ird] = 1'b1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
